// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor for the 96 MHz domain.
// Holds sys_rst until the PLL has stayed locked for a settle period and the
// 12 MHz output measures within tolerance. Counts lock losses while running
// and latches a fault after repeated failed frequency checks.
module pll_lock_supervisor #(
    parameter int SETTLE_CYCLES = 9600,
    parameter int WINDOW        = 96,
    parameter int EXPECTED      = 12,
    parameter int TOL           = 1,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk_96MHz,
    input  logic       rst,
    input  logic       locked,
    input  logic       clk_12MHz,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic       freq_ok,
    output logic [7:0] lock_loss_count
);

    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
    localparam int EW  = $clog2(WINDOW + 1);
    localparam int EW1 = EW + 1;
    localparam int RW  = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        CHECK,
        RUN,
        FAULT
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            locked_p0;
    logic            locked_s;
    logic            c12_p0;
    logic            c12_s;
    logic            c12_q;
    logic            c12_edge;

    logic [SW-1:0]   settle_cnt;
    logic [EW-1:0]   win_cnt;
    logic [EW-1:0]   edge_cnt;
    logic [EW:0]     edges_total;
    logic [RW-1:0]   retry;
    logic            run_fail;

    logic            settle_done;
    logic            win_end;
    logic            win_pass;
    logic            retry_last;

    // Window verdict: edge count within TOL of EXPECTED
    function automatic logic window_pass(input logic [EW:0] edges);
        int diff;
        diff = int'(edges) - EXPECTED;
        if (diff < 0) diff = -diff;
        return (diff <= TOL);
    endfunction

    // Saturating increment for the 8-bit lock-loss counter
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Two-flop synchronisers for the asynchronous lock flag and the sampled 12 MHz clock
    always_ff @(posedge clk_96MHz) begin
        if (rst) begin
            locked_p0 <= 1'b0;
            locked_s  <= 1'b0;
            c12_p0    <= 1'b0;
            c12_s     <= 1'b0;
            c12_q     <= 1'b0;
        end else begin
            locked_p0 <= locked;
            locked_s  <= locked_p0;
            c12_p0    <= clk_12MHz;
            c12_s     <= c12_p0;
            c12_q     <= c12_s;
        end
    end

    assign c12_edge    = c12_s & ~c12_q;
    assign win_end     = (win_cnt == EW'(WINDOW - 1));
    // An edge on the final window cycle still belongs to this window
    assign edges_total = {1'b0, edge_cnt} + EW1'(c12_edge);
    assign win_pass    = window_pass(edges_total);
    assign settle_done = (settle_cnt == SW'(SETTLE_CYCLES - 1));
    assign retry_last  = (retry == RW'(MAX_RETRIES - 1));

    // Next-state decision; lock loss takes priority over any window result
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOCK: if (locked_s) state_nxt = SETTLE;
            SETTLE: begin
                if (!locked_s)        state_nxt = WAIT_LOCK;
                else if (settle_done) state_nxt = CHECK;
            end
            CHECK: begin
                if (!locked_s)        state_nxt = WAIT_LOCK;
                else if (win_end) begin
                    if (win_pass)        state_nxt = RUN;
                    else if (retry_last) state_nxt = FAULT;
                    else                 state_nxt = SETTLE;
                end
            end
            RUN: begin
                if (!locked_s || (win_end && !win_pass && run_fail)) state_nxt = WAIT_LOCK;
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = WAIT_LOCK;
        endcase
    end

    // State register, counters and outputs registered from the next state
    always_ff @(posedge clk_96MHz) begin
        if (rst) begin
            state           <= WAIT_LOCK;
            settle_cnt      <= '0;
            win_cnt         <= '0;
            edge_cnt        <= '0;
            retry           <= '0;
            run_fail        <= 1'b0;
            sys_rst         <= 1'b1;
            ready           <= 1'b0;
            fault           <= 1'b0;
            freq_ok         <= 1'b0;
            lock_loss_count <= 8'd0;
        end else begin
            state   <= state_nxt;
            sys_rst <= (state_nxt != RUN);
            ready   <= (state_nxt == RUN);
            fault   <= (state_nxt == FAULT);

            if (state == SETTLE && state_nxt == SETTLE) settle_cnt <= settle_cnt + SW'(1);
            else                                        settle_cnt <= '0;

            if (state != CHECK && state_nxt == CHECK) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end else if (state == CHECK || state == RUN) begin
                if (win_end) begin
                    win_cnt  <= '0;
                    edge_cnt <= '0;
                    freq_ok  <= win_pass;
                end else begin
                    win_cnt  <= win_cnt + EW'(1);
                    edge_cnt <= edge_cnt + EW'(c12_edge);
                end
            end

            if (state == CHECK && state_nxt == RUN)         retry <= '0;
            else if (state == CHECK && state_nxt == SETTLE) retry <= retry + RW'(1);

            // Two failed windows in a row drop RUN; a single one only clears freq_ok
            if (state != RUN)  run_fail <= 1'b0;
            else if (win_end)  run_fail <= !win_pass;

            if (state == RUN && state_nxt == WAIT_LOCK) lock_loss_count <= sat_inc(lock_loss_count);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: timestamp/history based reference model
// compared every cycle, plus directed latency, retry, tolerance, glitch,
// saturation and randomized soak scenarios.
module tb_pll_lock_supervisor;

    localparam int SETTLE_CYCLES = 16;
    localparam int WINDOW        = 32;
    localparam int EXPECTED      = 4;
    localparam int TOL           = 1;
    localparam int MAX_RETRIES   = 3;
    localparam int HMAX          = 32768;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_CHECK  = 2;
    localparam int M_RUN    = 3;
    localparam int M_FAULT  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       locked;
    logic       clk_12MHz;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic       freq_ok;
    logic [7:0] lock_loss_count;

    int errors = 0;
    int checks = 0;

    pll_lock_supervisor #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .WINDOW       (WINDOW),
        .EXPECTED     (EXPECTED),
        .TOL          (TOL),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .clk_96MHz      (clk),
        .rst            (rst),
        .locked         (locked),
        .clk_12MHz      (clk_12MHz),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .fault          (fault),
        .freq_ok        (freq_ok),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    // 12 MHz stimulus: pattern repeating every 32 cycles with c12n rising edges,
    // so any 32 consecutive samples hold exactly c12n edges.
    int c12n = 4;
    int gcnt = 0;

    function automatic logic c12_level(input int g, input int n);
        int sp;
        if (n <= 0) return 1'b0;
        sp = 32 / n;
        return ((g % sp) < (sp / 2)) && (g < n * sp);
    endfunction

    initial begin
        clk_12MHz = 1'b0;
        gcnt = int'($urandom_range(31, 0));
        forever begin
            @(negedge clk);
            gcnt = (gcnt + 1) % 32;
            clk_12MHz = c12_level(gcnt, c12n);
        end
    end

    // Reference model: input history plus timestamps of settle start and window origin
    bit lk_h [HMAX];
    bit ck_h [HMAX];
    int t, m_mode, m_mark, m_worg, m_retry, m_runfail, m_fok, m_cnt;

    task automatic model_reset();
        t = 0; m_mode = M_IDLE; m_mark = 0; m_worg = 0;
        m_retry = 0; m_runfail = 0; m_fok = 0; m_cnt = 0;
    endtask

    function automatic int edge_at(input int k);
        if (k < 2) return 0;
        if (k == 2) return int'(ck_h[0]);
        return int'(ck_h[k-2] & ~ck_h[k-3]);
    endfunction

    task automatic model_step(input logic lk_in, input logic ck_in);
        int ls, n, d;
        bit wend, pass;
        if (t >= HMAX) begin
            $display("FAIL model_history: t=%0d limit=%0d", t, HMAX);
            $fatal(1, "history overflow");
        end
        lk_h[t] = lk_in;
        ck_h[t] = ck_in;
        ls = (t >= 2) ? int'(lk_h[t-2]) : 0;
        wend = 1'b0;
        pass = 1'b0;
        if ((m_mode == M_CHECK || m_mode == M_RUN) && t > m_worg && ((t - m_worg) % WINDOW) == 0) begin
            wend = 1'b1;
            n = 0;
            for (int k = t - WINDOW + 1; k <= t; k++) n += edge_at(k);
            d = n - EXPECTED;
            if (d < 0) d = -d;
            pass = (d <= TOL);
            m_fok = int'(pass);
        end
        case (m_mode)
            M_IDLE: if (ls != 0) begin m_mode = M_SETTLE; m_mark = t; end
            M_SETTLE: begin
                if (ls == 0) m_mode = M_IDLE;
                else if (t - m_mark == SETTLE_CYCLES) begin m_mode = M_CHECK; m_worg = t; end
            end
            M_CHECK: begin
                if (ls == 0) m_mode = M_IDLE;
                else if (wend) begin
                    if (pass) begin m_mode = M_RUN; m_retry = 0; m_runfail = 0; end
                    else if (m_retry + 1 == MAX_RETRIES) m_mode = M_FAULT;
                    else begin m_retry++; m_mode = M_SETTLE; m_mark = t; end
                end
            end
            M_RUN: begin
                if (wend) m_runfail = pass ? 0 : m_runfail + 1;
                if (ls == 0 || m_runfail >= 2) begin
                    m_mode = M_IDLE;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            default: ;
        endcase
        t++;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic sig_val(input int which);
        case (which)
            0:       return sys_rst;
            1:       return ready;
            2:       return fault;
            default: return freq_ok;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int maxc, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < maxc && !hit; i++) begin
            @(posedge clk); #1;
            if (sig_val(which) === val) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: signal %0d did not reach %0b within %0d cycles", nm, which, val, maxc);
        end
    endtask

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step(locked, clk_12MHz);
        #1;
        check("cyc_sys_rst", 32'(sys_rst), 32'(m_mode != M_RUN));
        check("cyc_ready",   32'(ready),   32'(m_mode == M_RUN));
        check("cyc_fault",   32'(fault),   32'(m_mode == M_FAULT));
        check("cyc_freq_ok", 32'(freq_ok), m_fok);
        check("cyc_count",   32'(lock_loss_count), m_cnt);
    end

    task automatic restart(input int n);
        @(negedge clk);
        rst = 1'b1; locked = 1'b0; c12n = n;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int tn [3];
        tn = '{5, 3, 6};
        rst = 1'b1;
        locked = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sys_rst", 32'(sys_rst), 32'd1);
        check("rst_ready",   32'(ready),   32'd0);
        check("rst_fault",   32'(fault),   32'd0);
        check("rst_freq_ok", 32'(freq_ok), 32'd0);
        check("rst_count",   32'(lock_loss_count), 32'd0);

        // Release latency with a correct clock
        c12n = 4;
        rst = 1'b0;
        repeat (10) @(negedge clk);
        locked = 1'b1;
        repeat (50) @(posedge clk); #1;
        check("rel_hold", 32'(sys_rst), 32'd1);
        @(posedge clk); #1;
        check("rel_sys_rst", 32'(sys_rst), 32'd0);
        check("rel_ready",   32'(ready),   32'd1);
        check("rel_freq_ok", 32'(freq_ok), 32'd1);
        check("rel_count",   32'(lock_loss_count), 32'd0);

        // One-cycle lock drop in RUN, then full re-release
        repeat ($urandom_range(40, 1)) @(negedge clk);
        locked = 1'b0;
        @(posedge clk);
        @(negedge clk);
        locked = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("loss_sys_rst", 32'(sys_rst), 32'd1);
        check("loss_ready",   32'(ready),   32'd0);
        check("loss_count",   32'(lock_loss_count), 32'd1);
        repeat (48) @(posedge clk); #1;
        check("rerel_hold", 32'(sys_rst), 32'd1);
        @(posedge clk); #1;
        check("rerel_sys_rst", 32'(sys_rst), 32'd0);

        // Bad clock: three failed checks lead to fault
        restart(2);
        repeat ($urandom_range(25, 15)) @(negedge clk);
        locked = 1'b1;
        repeat (146) @(posedge clk); #1;
        check("bad_pre_fault", 32'(fault), 32'd0);
        @(posedge clk); #1;
        check("bad_fault",   32'(fault),   32'd1);
        check("bad_sys_rst", 32'(sys_rst), 32'd1);
        check("bad_freq_ok", 32'(freq_ok), 32'd0);
        c12n = 4;
        repeat (10) begin
            @(negedge clk);
            locked = ~locked;
        end
        locked = 1'b1;
        repeat (80) @(negedge clk);
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_ready",  32'(ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("fault_clear", 32'(fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Tolerance edges: 5 and 3 pass, 6 fails
        for (int i = 0; i < 3; i++) begin
            restart(tn[i]);
            repeat ($urandom_range(30, 20)) @(negedge clk);
            locked = 1'b1;
            repeat (50) @(posedge clk); #1;
            check($sformatf("tol%0d_hold", tn[i]), 32'(ready), 32'd0);
            @(posedge clk); #1;
            check($sformatf("tol%0d_ready", tn[i]), 32'(ready), 32'(tn[i] != 6));
            if (tn[i] == 6) begin
                repeat (96) @(posedge clk); #1;
                check("tol6_fault", 32'(fault), 32'd1);
            end
        end

        // Lock glitch during SETTLE restarts the full latency
        restart(4);
        repeat (20) @(negedge clk);
        locked = 1'b1;
        repeat (10) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        repeat (50) @(posedge clk); #1;
        check("glitch_hold", 32'(sys_rst), 32'd1);
        @(posedge clk); #1;
        check("glitch_sys_rst", 32'(sys_rst), 32'd0);
        check("glitch_count",   32'(lock_loss_count), 32'd0);

        // Lock-loss counter saturation
        restart(4);
        repeat (5) @(negedge clk);
        locked = 1'b1;
        for (int i = 0; i < 260; i++) begin
            wait_sig(1, 1'b1, 80, "sat_ready");
            @(negedge clk);
            locked = 1'b0;
            @(negedge clk);
            locked = 1'b1;
            wait_sig(1, 1'b0, 6, "sat_drop");
        end
        wait_sig(1, 1'b1, 80, "sat_ready_final");
        check("sat_count", 32'(lock_loss_count), 32'd255);

        // One failed window in RUN only clears freq_ok; the second drops RUN
        c12n = 6;
        wait_sig(3, 1'b0, 80, "run_fail1");
        check("run_fail1_ready",   32'(ready),   32'd1);
        check("run_fail1_sys_rst", 32'(sys_rst), 32'd0);
        wait_sig(0, 1'b1, 80, "run_fail2");
        check("run_fail2_count", 32'(lock_loss_count), 32'd255);

        // Reset mid-operation clears the counter
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_count", 32'(lock_loss_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        c12n = 4;
        locked = 1'b0;

        // Randomized soak checked by the per-cycle model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(999, 0) == 0);
            if ($urandom_range(149, 0) == 0) locked = ~locked;
            if (cyc % 97 == 0) c12n = int'($urandom_range(6, 2));
        end

        rst = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
